id_ex_alu_decode: RTL and testbench

Registered ID/EX decode stage for the MIPS datapath. It decodes the 32-bit instruction held in ID into the 4-bit ALU operation code, selects and extends the ALU operands, and resolves the destination register. All of this is captured into the ID/EX pipeline register that drives the EX-stage ALU. The stage supports stall, flush, and valid tracking, and flags instructions the ALU cannot execute.

---
 rtl/id_ex_alu_decode.sv | 161 ++++++++++++++++
 tb/tb_id_ex_alu_decode.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_decode.sv
// ID/EX decode stage: turns the ID instruction into ALU operands, op code and destination,
// captured into the ID/EX register. Define ID_EX_IMM_OPS_EN to decode the I-type ALU opcodes.
module id_ex_alu_decode #(
    parameter int unsigned LEN_DATA = 32,
    parameter int unsigned LEN_OP   = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IN_VALID,
    input  logic [31:0]         INSTRUCTION,
    input  logic [LEN_DATA-1:0] RS_DATA,
    input  logic [LEN_DATA-1:0] RT_DATA,
    input  logic                STALL,
    input  logic                FLUSH,
    output logic [LEN_DATA-1:0] ALU_A,
    output logic [LEN_DATA-1:0] ALU_B,
    output logic [LEN_OP-1:0]   ALU_OPCODE,
    output logic [4:0]          WRITE_REG,
    output logic                REG_WRITE,
    output logic                OUT_VALID,
    output logic                ILLEGAL
);

    localparam logic [LEN_OP-1:0] ALU_SLL = LEN_OP'(0);
    localparam logic [LEN_OP-1:0] ALU_SRL = LEN_OP'(1);
    localparam logic [LEN_OP-1:0] ALU_SRA = LEN_OP'(2);
    localparam logic [LEN_OP-1:0] ALU_ADD = LEN_OP'(3);
    localparam logic [LEN_OP-1:0] ALU_SUB = LEN_OP'(4);
    localparam logic [LEN_OP-1:0] ALU_AND = LEN_OP'(5);
    localparam logic [LEN_OP-1:0] ALU_OR  = LEN_OP'(6);
    localparam logic [LEN_OP-1:0] ALU_XOR = LEN_OP'(7);
    localparam logic [LEN_OP-1:0] ALU_NOR = LEN_OP'(8);

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
`ifdef ID_EX_IMM_OPS_EN
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [LEN_DATA-1:0] LUI_SHIFT = LEN_DATA'(16);
`endif

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [LEN_DATA-1:0] shamt_zx;
    logic [LEN_DATA-1:0] imm_sx;
    logic [LEN_DATA-1:0] imm_zx;
    logic                unused_rs_field;

    assign opcode          = INSTRUCTION[31:26];
    assign rt              = INSTRUCTION[20:16];
    assign rd              = INSTRUCTION[15:11];
    assign funct           = INSTRUCTION[5:0];
    assign shamt_zx        = LEN_DATA'(INSTRUCTION[10:6]);
    assign imm_sx          = LEN_DATA'($signed(INSTRUCTION[15:0]));
    assign imm_zx          = LEN_DATA'(INSTRUCTION[15:0]);
    // rs is read by the register file upstream; only its data arrives here
    assign unused_rs_field = ^{INSTRUCTION[25:21], imm_zx};

    logic [LEN_DATA-1:0] dec_a;
    logic [LEN_DATA-1:0] dec_b;
    logic [LEN_OP-1:0]   dec_op;
    logic [4:0]          dec_wreg;
    logic                dec_regw;
    logic                dec_legal;

    // Combinational decode; fields are don't-care when dec_legal is low
    always_comb begin
        dec_a     = RS_DATA;
        dec_b     = RT_DATA;
        dec_op    = ALU_ADD;
        dec_wreg  = rt;
        dec_regw  = (rt != 5'd0);
        dec_legal = 1'b1;
        case (opcode)
            OPC_RTYPE: begin
                dec_wreg = rd;
                dec_regw = (rd != 5'd0);
                case (funct)
                    6'h00: begin dec_op = ALU_SLL; dec_a = shamt_zx; end
                    6'h02: begin dec_op = ALU_SRL; dec_a = shamt_zx; end
                    6'h03: begin dec_op = ALU_SRA; dec_a = shamt_zx; end
                    6'h04: dec_op = ALU_SLL;
                    6'h06: dec_op = ALU_SRL;
                    6'h07: dec_op = ALU_SRA;
                    6'h21: dec_op = ALU_ADD;
                    6'h23: dec_op = ALU_SUB;
                    6'h24: dec_op = ALU_AND;
                    6'h25: dec_op = ALU_OR;
                    6'h26: dec_op = ALU_XOR;
                    6'h27: dec_op = ALU_NOR;
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_LW: dec_b = imm_sx;
            OPC_SW: begin
                dec_b    = imm_sx;
                dec_wreg = 5'd0;
                dec_regw = 1'b0;
            end
`ifdef ID_EX_IMM_OPS_EN
            OPC_ADDI, OPC_ADDIU: dec_b = imm_sx;
            OPC_ANDI: begin dec_op = ALU_AND; dec_b = imm_zx; end
            OPC_ORI:  begin dec_op = ALU_OR;  dec_b = imm_zx; end
            OPC_XORI: begin dec_op = ALU_XOR; dec_b = imm_zx; end
            OPC_LUI: begin
                dec_op = ALU_SLL;
                dec_a  = LUI_SHIFT;
                dec_b  = imm_zx;
            end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    // ID/EX register: reset > flush > stall > load; illegal and idle slots load as bubbles
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_OPCODE <= ALU_ADD;
            WRITE_REG  <= '0;
            REG_WRITE  <= 1'b0;
            OUT_VALID  <= 1'b0;
            ILLEGAL    <= 1'b0;
        end else if (FLUSH) begin
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_OPCODE <= ALU_ADD;
            WRITE_REG  <= '0;
            REG_WRITE  <= 1'b0;
            OUT_VALID  <= 1'b0;
            ILLEGAL    <= 1'b0;
        end else if (!STALL) begin
            if (IN_VALID && dec_legal) begin
                ALU_A      <= dec_a;
                ALU_B      <= dec_b;
                ALU_OPCODE <= dec_op;
                WRITE_REG  <= dec_wreg;
                REG_WRITE  <= dec_regw;
                OUT_VALID  <= 1'b1;
                ILLEGAL    <= 1'b0;
            end else begin
                ALU_A      <= '0;
                ALU_B      <= '0;
                ALU_OPCODE <= ALU_ADD;
                WRITE_REG  <= '0;
                REG_WRITE  <= 1'b0;
                OUT_VALID  <= IN_VALID;
                ILLEGAL    <= IN_VALID;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// Directed bench for id_ex_alu_decode; I-type checks follow ID_EX_IMM_OPS_EN.
module tb_id_ex_alu_decode;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic [31:0] INSTRUCTION;
    logic [31:0] RS_DATA;
    logic [31:0] RT_DATA;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [3:0]  ALU_OPCODE;
    logic [4:0]  WRITE_REG;
    logic        REG_WRITE;
    logic        OUT_VALID;
    logic        ILLEGAL;

    int checks   = 0;
    int failures = 0;

    id_ex_alu_decode dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .INSTRUCTION(INSTRUCTION),
        .RS_DATA(RS_DATA), .RT_DATA(RT_DATA), .STALL(STALL), .FLUSH(FLUSH),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OPCODE(ALU_OPCODE), .WRITE_REG(WRITE_REG),
        .REG_WRITE(REG_WRITE), .OUT_VALID(OUT_VALID), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [4:0] wreg, input logic regw,
                           input logic vld, input logic ill);
        chk({tag, ".alu_a"}, ALU_A, a);
        chk({tag, ".alu_b"}, ALU_B, b);
        chk({tag, ".opcode"}, 32'(ALU_OPCODE), 32'(op));
        chk({tag, ".write_reg"}, 32'(WRITE_REG), 32'(wreg));
        chk({tag, ".reg_write"}, 32'(REG_WRITE), 32'(regw));
        chk({tag, ".out_valid"}, 32'(OUT_VALID), 32'(vld));
        chk({tag, ".illegal"}, 32'(ILLEGAL), 32'(ill));
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                         input logic vld, input logic stl, input logic fl);
        INSTRUCTION = instr;
        RS_DATA     = rs;
        RT_DATA     = rt;
        IN_VALID    = vld;
        STALL       = stl;
        FLUSH       = fl;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset with random inputs: async value, then held across an edge
        RESET = 1'b1;
        drive($urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
        #2;
        chk_all("reset_async", 32'h0, 32'h0, 4'h3, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("reset_held", 32'h0, 32'h0, 4'h3, 5'd0, 1'b0, 1'b0, 1'b0);

        RESET = 1'b0;
        drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("addu", 32'd5, 32'd7, 4'h3, 5'd3, 1'b1, 1'b1, 1'b0);

        drive(rtype(5'd0, 5'd2, 5'd4, 5'd3, 6'h03), 32'h1111_1111, 32'hF000_0000, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("sra", 32'd3, 32'hF000_0000, 4'h2, 5'd4, 1'b1, 1'b1, 1'b0);

        drive(rtype(5'd9, 5'd10, 5'd11, 5'd31, 6'h06), 32'd12, 32'h8000_0001, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("srlv", 32'd12, 32'h8000_0001, 4'h1, 5'd11, 1'b1, 1'b1, 1'b0);

        drive(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h23), 32'd100, 32'd1, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("subu", 32'd100, 32'd1, 4'h4, 5'd12, 1'b1, 1'b1, 1'b0);

        drive(itype(6'h2B, 5'd1, 5'd2, 16'h0010), 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("sw", 32'h0000_1000, 32'h0000_0010, 4'h3, 5'd0, 1'b0, 1'b1, 1'b0);

        drive(itype(6'h23, 5'd1, 5'd7, 16'hFFFC), 32'h0000_2000, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("lw", 32'h0000_2000, 32'hFFFF_FFFC, 4'h3, 5'd7, 1'b1, 1'b1, 1'b0);

`ifdef ID_EX_IMM_OPS_EN
        drive(itype(6'h0F, 5'd0, 5'd5, 16'h1234), 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("lui", 32'd16, 32'h0000_1234, 4'h0, 5'd5, 1'b1, 1'b1, 1'b0);

        drive(itype(6'h08, 5'd1, 5'd6, 16'hFFFF), 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("addi", 32'd9, 32'hFFFF_FFFF, 4'h3, 5'd6, 1'b1, 1'b1, 1'b0);

        drive(itype(6'h0D, 5'd1, 5'd6, 16'hFFFF), 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("ori", 32'd9, 32'h0000_FFFF, 4'h6, 5'd6, 1'b1, 1'b1, 1'b0);

        drive(itype(6'h0E, 5'd1, 5'd0, 16'h8001), 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("xori_rt0", 32'd9, 32'h0000_8001, 4'h7, 5'd0, 1'b0, 1'b1, 1'b0);
`else
        drive(itype(6'h0E, 5'd1, 5'd6, 16'h00FF), 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("xori_off", 32'h0, 32'h0, 4'h3, 5'd0, 1'b0, 1'b1, 1'b1);

        drive(itype(6'h0F, 5'd0, 5'd5, 16'h1234), 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("lui_off", 32'h0, 32'h0, 4'h3, 5'd0, 1'b0, 1'b1, 1'b1);
`endif

        // NOR load, then three stall cycles with unrelated inputs
        drive(rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h27), 32'h0F0F_0000, 32'h00FF_00FF, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("nor", 32'h0F0F_0000, 32'h00FF_00FF, 4'h8, 5'd8, 1'b1, 1'b1, 1'b0);
        drive(rtype(5'd3, 5'd4, 5'd9, 5'd0, 6'h24), 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("stall1", 32'h0F0F_0000, 32'h00FF_00FF, 4'h8, 5'd8, 1'b1, 1'b1, 1'b0);
        drive(rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h2A), 32'd3, 32'd4, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("stall2", 32'h0F0F_0000, 32'h00FF_00FF, 4'h8, 5'd8, 1'b1, 1'b1, 1'b0);
        drive(32'h0, 32'd5, 32'd6, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("stall3", 32'h0F0F_0000, 32'h00FF_00FF, 4'h8, 5'd8, 1'b1, 1'b1, 1'b0);

        drive(rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h25), 32'd1, 32'd2, 1'b1, 1'b1, 1'b1);
        step();
        chk_all("stall_flush", 32'h0, 32'h0, 4'h3, 5'd0, 1'b0, 1'b0, 1'b0);

        drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("slt_illegal", 32'h0, 32'h0, 4'h3, 5'd0, 1'b0, 1'b1, 1'b1);

        // Stalled illegal stays illegal; the next load clears it
        drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("illegal_stall", 32'h0, 32'h0, 4'h3, 5'd0, 1'b0, 1'b1, 1'b1);
        drive(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h21), 32'd11, 32'd22, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("addu_rd0", 32'd11, 32'd22, 4'h3, 5'd0, 1'b0, 1'b1, 1'b0);

        drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd11, 32'd22, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("idle", 32'h0, 32'h0, 4'h3, 5'd0, 1'b0, 1'b0, 1'b0);

        drive(rtype(5'd1, 5'd2, 5'd13, 5'd4, 6'h00), 32'd11, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("sll", 32'd4, 32'h0000_0003, 4'h0, 5'd13, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle, released while stalled
        RESET = 1'b1;
        #1;
        chk_all("reset_mid", 32'h0, 32'h0, 4'h3, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(rtype(5'd1, 5'd2, 5'd14, 5'd0, 6'h26), 32'd6, 32'd3, 1'b1, 1'b1, 1'b0);
        #2;
        RESET = 1'b0;
        step();
        chk_all("reset_stall", 32'h0, 32'h0, 4'h3, 5'd0, 1'b0, 1'b0, 1'b0);
        STALL = 1'b0;
        step();
        chk_all("xor_after", 32'd6, 32'd3, 4'h7, 5'd14, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
